// File: rtl/jedro_1_mem_arbiter.sv
// Arbitrates the IFU and LSU onto one memory port with a single outstanding
// transaction; the LSU has priority, bounded by a streak limit while the IFU waits.
module jedro_1_mem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned MAX_LSU_STREAK = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ifu_req_i,
  input  logic [DATA_WIDTH-1:0] ifu_addr_i,
  output logic                  ifu_gnt_o,
  output logic                  ifu_rvalid_o,
  output logic [DATA_WIDTH-1:0] ifu_rdata_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [3:0]            lsu_be_i,
  input  logic [DATA_WIDTH-1:0] lsu_addr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  localparam int unsigned SW = 3;
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;
  typedef enum logic {OWN_LSU = 1'b0, OWN_IFU = 1'b1} owner_e;

  state_e        r_state, w_state_nxt;
  owner_e        r_owner, w_owner_nxt, w_owner;
  logic [SW-1:0] r_streak, w_streak_nxt;
  logic          w_arb, w_req, w_gnt, w_rsp, w_req_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state  <= IDLE;
      r_owner  <= OWN_LSU;
      r_streak <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_owner  <= w_owner_nxt;
      r_streak <= w_streak_nxt;
    end
  end

  // Arbitration and next state; WAIT_RSP re-arbitrates in the response cycle.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_streak_nxt = r_streak;
    w_owner      = r_owner;
    w_arb        = 1'b0;
    w_req        = 1'b0;
    w_rsp        = 1'b0;
    case (r_state)
      IDLE:     w_arb = 1'b1;
      ISSUE:    w_req = 1'b1;
      WAIT_RSP: begin
        w_rsp = mem_rvalid_i;
        w_arb = mem_rvalid_i;
      end
      default:  w_arb = 1'b0;
    endcase
    if (w_arb && (ifu_req_i || lsu_req_i)) begin
      w_req   = 1'b1;
      w_owner = (ifu_req_i && (!lsu_req_i || (r_streak == STREAK_MAX))) ? OWN_IFU : OWN_LSU;
    end
    w_gnt = w_req && mem_gnt_i;
    if (w_gnt) begin
      w_state_nxt = WAIT_RSP;
      w_owner_nxt = w_owner;
      if (w_owner == OWN_IFU) begin
        w_streak_nxt = '0;
      end else if (ifu_req_i && (r_streak < STREAK_MAX)) begin
        w_streak_nxt = r_streak + SW'(1);
      end
    end else if (w_req) begin
      w_state_nxt = ISSUE;
      w_owner_nxt = w_owner;
    end else if (w_rsp) begin
      w_state_nxt = IDLE;
    end
  end

  // Port muxing; everything is forced low while reset is asserted.
  always_comb begin
    w_req_q      = w_req && rstn_i;
    mem_req_o    = w_req_q;
    mem_we_o     = 1'b0;
    mem_be_o     = 4'h0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    if (w_req_q) begin
      if (w_owner == OWN_IFU) begin
        mem_be_o   = 4'hF;
        mem_addr_o = ifu_addr_i;
      end else begin
        mem_we_o    = lsu_we_i;
        mem_be_o    = lsu_be_i;
        mem_addr_o  = lsu_addr_i;
        mem_wdata_o = lsu_wdata_i;
      end
    end
    ifu_gnt_o    = w_req_q && mem_gnt_i && (w_owner == OWN_IFU);
    lsu_gnt_o    = w_req_q && mem_gnt_i && (w_owner == OWN_LSU);
    ifu_rvalid_o = rstn_i && w_rsp && (r_owner == OWN_IFU);
    lsu_rvalid_o = rstn_i && w_rsp && (r_owner == OWN_LSU);
    ifu_rdata_o  = ifu_rvalid_o ? mem_rdata_i : '0;
    lsu_rdata_o  = lsu_rvalid_o ? mem_rdata_i : '0;
  end

endmodule

// File: tb/tb_jedro_1_mem_arbiter.sv
// Bench for jedro_1_mem_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_jedro_1_mem_arbiter;
  localparam int unsigned DW   = 32;
  localparam int          MAXS = 4;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          ifu_req_i, ifu_gnt_o, ifu_rvalid_o;
  logic [DW-1:0] ifu_addr_i, ifu_rdata_o;
  logic          lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o;
  logic [3:0]    lsu_be_i;
  logic [DW-1:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
  logic          mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
  logic [3:0]    mem_be_o;
  logic [DW-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  jedro_1_mem_arbiter #(.DATA_WIDTH(DW), .MAX_LSU_STREAK(MAXS)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .ifu_req_i(ifu_req_i), .ifu_addr_i(ifu_addr_i), .ifu_gnt_o(ifu_gnt_o),
    .ifu_rvalid_o(ifu_rvalid_o), .ifu_rdata_o(ifu_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Reference model: one outstanding response, or one issued-but-unaccepted request.
  bit m_busy, m_busy_ifu, m_busy_we, m_lock, m_lock_ifu;
  int m_streak;

  // DUT samples from the most recent step, used by directed checks.
  logic          obs_ifu_gnt, obs_lsu_gnt, obs_ifu_rv, obs_lsu_rv, obs_req, obs_we;
  logic [DW-1:0] obs_addr, obs_ifu_rdata;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_busy_ifu = 0; m_busy_we = 0; m_lock = 0; m_lock_ifu = 0; m_streak = 0;
  endtask

  task automatic idle_inputs();
    ifu_req_i = 0; ifu_addr_i = '0; lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = 4'h0;
    lsu_addr_i = '0; lsu_wdata_i = '0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
  endtask

  // One clock cycle: inputs already applied; check mid-cycle, advance the model.
  task automatic step();
    bit resp, arb, req, own_ifu, gnt;
    logic [DW-1:0] e_addr, e_wd;
    logic [3:0] e_be;
    logic e_we;
    @(negedge clk_i);
    resp = m_busy && mem_rvalid_i;
    arb  = !m_lock && (!m_busy || mem_rvalid_i);
    req = 0; own_ifu = 0;
    if (m_lock) begin
      req = 1; own_ifu = m_lock_ifu;
    end else if (arb && (ifu_req_i || lsu_req_i)) begin
      req = 1; own_ifu = ifu_req_i && (!lsu_req_i || m_streak == MAXS);
    end
    gnt = req && mem_gnt_i;
    e_we = 0; e_be = 4'h0; e_addr = '0; e_wd = '0;
    if (req && own_ifu) begin
      e_be = 4'hF; e_addr = ifu_addr_i;
    end else if (req) begin
      e_we = lsu_we_i; e_be = lsu_be_i; e_addr = lsu_addr_i; e_wd = lsu_wdata_i;
    end
    chk1("mem_req", mem_req_o, req);
    chk1("mem_we", mem_we_o, e_we);
    chkw("mem_be", DW'(mem_be_o), DW'(e_be));
    chkw("mem_addr", mem_addr_o, e_addr);
    chkw("mem_wdata", mem_wdata_o, e_wd);
    chk1("ifu_gnt", ifu_gnt_o, gnt && own_ifu);
    chk1("lsu_gnt", lsu_gnt_o, gnt && !own_ifu);
    chk1("ifu_rvalid", ifu_rvalid_o, resp && m_busy_ifu);
    chk1("lsu_rvalid", lsu_rvalid_o, resp && !m_busy_ifu);
    if (resp && m_busy_ifu) chkw("ifu_rdata", ifu_rdata_o, mem_rdata_i);
    if (resp && !m_busy_ifu && !m_busy_we) chkw("lsu_rdata", lsu_rdata_o, mem_rdata_i);
    obs_ifu_gnt = ifu_gnt_o; obs_lsu_gnt = lsu_gnt_o; obs_ifu_rv = ifu_rvalid_o;
    obs_lsu_rv = lsu_rvalid_o; obs_req = mem_req_o; obs_we = mem_we_o;
    obs_addr = mem_addr_o; obs_ifu_rdata = ifu_rdata_o;
    if (gnt) begin
      m_busy = 1; m_busy_ifu = own_ifu; m_busy_we = !own_ifu && lsu_we_i; m_lock = 0;
      if (own_ifu) m_streak = 0;
      else if (ifu_req_i && m_streak < MAXS) m_streak++;
    end else if (req) begin
      m_lock = 1; m_lock_ifu = own_ifu; m_busy = 0;
    end else if (resp) begin
      m_busy = 0;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk1({tag, "_mem_req"}, mem_req_o, 1'b0);
    chk1({tag, "_ifu_gnt"}, ifu_gnt_o, 1'b0);
    chk1({tag, "_lsu_gnt"}, lsu_gnt_o, 1'b0);
    chk1({tag, "_ifu_rvalid"}, ifu_rvalid_o, 1'b0);
    chk1({tag, "_lsu_rvalid"}, lsu_rvalid_o, 1'b0);
    chkw({tag, "_mem_addr"}, mem_addr_o, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_reset();
    rstn_i = 0;
    ifu_req_i = 1; lsu_req_i = 1; mem_gnt_i = 1; mem_rvalid_i = 1;
    #2 check_reset_outputs("por");
    @(posedge clk_i); @(posedge clk_i); #3;
    idle_inputs();
    rstn_i = 1;
    @(posedge clk_i); #1;

    // IFU-only read of 0x100 answered one cycle later
    ifu_req_i = 1; ifu_addr_i = 32'h100; mem_gnt_i = 1;
    step();
    chk1("r28_ifu_gnt", obs_ifu_gnt, 1'b1);
    chkw("r28_addr", obs_addr, 32'h100);
    ifu_req_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h13;
    step();
    chk1("r28_ifu_rvalid", obs_ifu_rv, 1'b1);
    chkw("r28_ifu_rdata", obs_ifu_rdata, 32'h13);
    chk1("r28_lsu_rvalid", obs_lsu_rv, 1'b0);
    idle_inputs();

    // Simultaneous requests: LSU write first, IFU granted in the lsu_rvalid cycle
    ifu_req_i = 1; ifu_addr_i = 32'h300; mem_gnt_i = 1;
    lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'hF; lsu_addr_i = 32'h200; lsu_wdata_i = 32'hDEADBEEF;
    step();
    chk1("r29_lsu_gnt", obs_lsu_gnt, 1'b1);
    chk1("r29_ifu_gnt0", obs_ifu_gnt, 1'b0);
    chk1("r29_we", obs_we, 1'b1);
    lsu_req_i = 0; lsu_we_i = 0; mem_rvalid_i = 1;
    step();
    chk1("r29_lsu_rvalid", obs_lsu_rv, 1'b1);
    chk1("r29_ifu_gnt", obs_ifu_gnt, 1'b1);
    ifu_req_i = 0;
    step();
    chk1("r29_ifu_rvalid", obs_ifu_rv, 1'b1);
    idle_inputs();

    // Continuous contention: LSU x4 then IFU, twice
    ifu_req_i = 1; ifu_addr_i = 32'h1000; lsu_req_i = 1; lsu_be_i = 4'h3; lsu_addr_i = 32'h2000;
    mem_gnt_i = 1; mem_rvalid_i = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk1("r30_ifu_order", obs_ifu_gnt, (i % 5) == 4);
      chk1("r30_lsu_order", obs_lsu_gnt, (i % 5) != 4);
    end
    ifu_req_i = 0; lsu_req_i = 0;
    step();
    idle_inputs();

    // Memory stalls an IFU request for three cycles while the LSU waits
    ifu_req_i = 1; ifu_addr_i = 32'h400;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("r31_req_held", obs_req, 1'b1);
      chkw("r31_addr", obs_addr, 32'h400);
      chk1("r31_lsu_gnt", obs_lsu_gnt, 1'b0);
      lsu_req_i = 1; lsu_addr_i = 32'h500; lsu_be_i = 4'h1;
    end
    mem_gnt_i = 1;
    step();
    chk1("r31_ifu_gnt", obs_ifu_gnt, 1'b1);
    chk1("r31_lsu_wait", obs_lsu_gnt, 1'b0);
    ifu_req_i = 0; mem_rvalid_i = 1;
    step();
    chk1("r31_lsu_next", obs_lsu_gnt, 1'b1);
    lsu_req_i = 0;
    step();
    chk1("r31_lsu_rvalid", obs_lsu_rv, 1'b1);
    idle_inputs();

    // Spurious rvalid while idle
    mem_rvalid_i = 1; mem_rdata_i = 32'h55;
    step();
    chk1("r33_ifu_rv", obs_ifu_rv, 1'b0);
    chk1("r33_lsu_rv", obs_lsu_rv, 1'b0);
    mem_rvalid_i = 0; ifu_req_i = 1; ifu_addr_i = 32'h600; mem_gnt_i = 1;
    step();
    chk1("r33_still_idle", obs_ifu_gnt, 1'b1);
    idle_inputs();

    // Reset while waiting for a response; the late response is dropped
    rstn_i = 0;
    ifu_req_i = 1; ifu_addr_i = 32'h700; mem_gnt_i = 1; mem_rvalid_i = 1;
    #2 check_reset_outputs("r32");
    #1 rstn_i = 1;
    model_reset();
    idle_inputs();
    mem_rvalid_i = 1; mem_rdata_i = 32'h77;
    step();
    chk1("r32_late_ifu_rv", obs_ifu_rv, 1'b0);
    mem_rvalid_i = 0; lsu_req_i = 1; lsu_addr_i = 32'h800; lsu_be_i = 4'hF; mem_gnt_i = 1;
    step();
    chk1("r32_after_gnt", obs_lsu_gnt, 1'b1);
    lsu_req_i = 0; mem_rvalid_i = 1;
    step();
    idle_inputs();

    // Random traffic; requesters hold their request until granted
    for (int c = 0; c < 1500; c++) begin
      if (!ifu_req_i || obs_ifu_gnt) begin
        ifu_req_i = 1'($urandom_range(0, 1)); ifu_addr_i = $urandom;
      end
      if (!lsu_req_i || obs_lsu_gnt) begin
        lsu_req_i = 1'($urandom_range(0, 1)); lsu_we_i = 1'($urandom_range(0, 1));
        lsu_be_i = 4'($urandom_range(0, 15)); lsu_addr_i = $urandom; lsu_wdata_i = $urandom;
      end
      mem_gnt_i    = ($urandom_range(0, 3) != 0);
      mem_rvalid_i = 1'($urandom_range(0, 1));
      mem_rdata_i  = $urandom;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/jedro_1_mem_arbiter.md
JEDRO_1_MEM_ARBITER -- requirements
Module: jedro_1_mem_arbiter

Interface
REQ-001 Param DATA_WIDTH, default 32, data and address width.
REQ-002 Param MAX_LSU_STREAK, default 4 (range 1..7), maximum consecutive LSU grants while the IFU is waiting.
REQ-003 Port clk_i, in, 1, single clock for the block.
REQ-004 Port rstn_i, in, 1, asynchronous active-low reset.
REQ-005 Port ifu_req_i, in, 1; ifu_addr_i, in, DATA_WIDTH: IFU read request and address.
REQ-006 Port ifu_gnt_o, out, 1; ifu_rvalid_o, out, 1; ifu_rdata_o, out, DATA_WIDTH: IFU grant, response valid and read data.
REQ-007 Port lsu_req_i, in, 1; lsu_we_i, in, 1; lsu_be_i, in, 4; lsu_addr_i, in, DATA_WIDTH; lsu_wdata_i, in, DATA_WIDTH: LSU request.
REQ-008 Port lsu_gnt_o, out, 1; lsu_rvalid_o, out, 1; lsu_rdata_o, out, DATA_WIDTH: LSU grant, response valid and read data.
REQ-009 Port mem_req_o, out, 1; mem_we_o, out, 1; mem_be_o, out, 4; mem_addr_o, out, DATA_WIDTH; mem_wdata_o, out, DATA_WIDTH: shared memory port request.
REQ-010 Port mem_gnt_i, in, 1; mem_rvalid_i, in, 1; mem_rdata_i, in, DATA_WIDTH: memory accept, response valid and response data.

Function
REQ-011 The FSM SHALL have states IDLE, ISSUE and WAIT_RSP, with a registered owner bit (IFU/LSU).
REQ-012 The arbiter SHALL allow exactly one outstanding memory transaction.
REQ-013 In IDLE with any request, the FSM SHALL select an owner and drive mem_req_o=1 in the same cycle (combinational) with that owner's fields.
REQ-014 When both requests are high, the LSU SHALL win unless streak_cnt==MAX_LSU_STREAK, in which case the IFU SHALL win.
REQ-015 streak_cnt (3 bit) SHALL increment on each LSU grant while ifu_req_i=1, SHALL clear on any IFU grant, and SHALL saturate at MAX_LSU_STREAK.
REQ-016 On an IFU issue, mem_we_o SHALL be 0, mem_be_o SHALL be 4'hF and mem_wdata_o SHALL be 0.
REQ-017 If mem_gnt_i=0 while mem_req_o=1, the FSM SHALL go to ISSUE and lock the owner; mem_req_o SHALL stay 1 with the owner's live fields until mem_gnt_i=1, and no re-arbitration SHALL occur.
REQ-018 The owner's gnt output SHALL equal mem_req_o & mem_gnt_i; the non-owner's gnt SHALL be 0.
REQ-019 On mem_req_o & mem_gnt_i, the FSM SHALL go to WAIT_RSP (owner registered); mem_req_o SHALL be 0 in WAIT_RSP.
REQ-020 In WAIT_RSP with mem_rvalid_i=1, the owner's rvalid output SHALL pulse 1 for that cycle, and the FSM SHALL arbitrate the next request in the same cycle (back-to-back, same rules as IDLE), otherwise it SHALL return to IDLE.
REQ-021 Write transactions SHALL also complete via mem_rvalid_i; lsu_rvalid_o SHALL pulse for writes, with lsu_rdata_o don't-care.
REQ-022 ifu_rdata_o and lsu_rdata_o SHALL both be combinational copies of mem_rdata_i, qualified only by their rvalid.
REQ-023 mem_rvalid_i in IDLE or ISSUE SHALL be ignored; no rvalid output SHALL assert.
REQ-024 Requesters SHALL hold req and fields stable until gnt; a dropped request before gnt in IDLE SHALL be simply not issued.

Reset
REQ-025 Asserting rstn_i low SHALL immediately force IDLE, owner=LSU, streak_cnt=0, and all gnt, rvalid and mem_req_o outputs to 0.
REQ-026 An in-flight transaction at reset SHALL be abandoned; its late mem_rvalid_i SHALL be ignored per REQ-023.
REQ-027 Address, data and be outputs SHALL be 0 whenever mem_req_o=0.

Verification
REQ-028 IFU-only read of 0x100, mem_gnt_i=1, rvalid after 1 cycle with rdata 0x00000013 -> ifu_gnt_o pulse in cycle 0, ifu_rvalid_o pulse with 0x00000013 in cycle 1, no LSU activity.
REQ-029 IFU and LSU requesting in the same IDLE cycle, LSU write of 0xDEADBEEF to 0x200 with be=0xF -> LSU granted first, mem_we_o=1, IFU granted in the lsu_rvalid_o cycle.
REQ-030 Both requesting continuously, MAX_LSU_STREAK=4 -> grant order LSU x4, IFU, LSU x4, IFU; streak_cnt returns to 0 after each IFU grant.
REQ-031 mem_gnt_i held 0 for 3 cycles while the IFU owns the port and the LSU raises a request -> mem_req_o stays 1 with the IFU address, the IFU is granted in cycle 3, and the LSU waits.
REQ-032 rstn_i pulsed low in WAIT_RSP, then mem_rvalid_i arrives -> all outputs 0 during reset, no rvalid forwarded afterwards, and the next request is arbitrated normally.
REQ-033 mem_rvalid_i pulsed while IDLE with no requests -> ifu_rvalid_o=lsu_rvalid_o=0 and the state is unchanged.
